resource_arbiter: RTL

RESOURCE_ARBITER -- requirements
Module: resource_arbiter

---
 rtl/svh_pkg.sv | 22 ++
 rtl/resource_arbiter_rr_pick.sv | 32 +++
 rtl/resource_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/svh_pkg.sv
// Shared types and helpers for the resource arbiter: FSM state encoding,
// default sizing constants and an index-to-one-hot decoder.
package svh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 64;
    localparam int MAX_N_REQ    = 16;

    function automatic logic [MAX_N_REQ-1:0] idx_to_onehot(input logic [3:0] idx);
        logic [MAX_N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/resource_arbiter_rr_pick.sv
// Rotating-priority picker: scans the request vector upward from a start
// index with wrap-around and reports the first set bit.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_start,
    output logic           o_found,
    output logic [IDW-1:0] o_idx
);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_pos;

    // Walk from the farthest candidate back to the start so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_start} + (IDW + 1)'(i);
            w_pos = (w_sum >= (IDW + 1)'(N)) ? IDW'(w_sum - (IDW + 1)'(N)) : IDW'(w_sum);
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin single-resource arbiter with a mandatory one-cycle gap between grants.
// Define ARB_TIMEOUT_EN to add a hold limit (MAX_HOLD) with forced release and requester masking.
module resource_arbiter
    import svh_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     timeout
);

    localparam int             IDW      = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > MAX_N_REQ || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
        $error("resource_arbiter: N_REQ or MAX_HOLD out of range");
    end

    arb_state_t       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic             r_gnt_valid, w_gnt_valid_nxt;
    logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic [IDW-1:0]   r_last_id, w_last_id_nxt;

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [IDW-1:0]   w_start;
    logic [IDW-1:0]   w_win;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0]      r_hold_cnt, w_hold_nxt;
    logic [N_REQ-1:0] r_mask, w_mask_nxt;
    logic             r_timeout, w_timeout_nxt;

    assign w_elig  = req & ~r_mask;
    assign timeout = r_timeout;
`else
    assign w_elig  = req;
    assign timeout = 1'b0;
`endif

    assign w_start = (r_last_id == LAST_IDX) ? '0 : r_last_id + IDW'(1);

    rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_pick (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_id_nxt    = r_gnt_id;
        w_last_id_nxt   = r_last_id;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt      = r_hold_cnt;
        w_mask_nxt      = r_mask & req;
        w_timeout_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt     = GRANT;
                    w_gnt_nxt       = N_REQ'(idx_to_onehot(4'(w_win)));
                    w_gnt_valid_nxt = 1'b1;
                    w_gnt_id_nxt    = w_win;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt      = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[r_gnt_id]) begin
                    w_state_nxt     = GAP;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_gnt_id_nxt    = '0;
                    w_last_id_nxt   = r_gnt_id;
                end
`ifdef ARB_TIMEOUT_EN
                // Forced release: the holder stays masked until it lets go of req.
                else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt          = GAP;
                    w_gnt_nxt            = '0;
                    w_gnt_valid_nxt      = 1'b0;
                    w_gnt_id_nxt         = '0;
                    w_last_id_nxt        = r_gnt_id;
                    w_timeout_nxt        = 1'b1;
                    w_mask_nxt[r_gnt_id] = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + 16'd1;
                end
`endif
            end
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_last_id   <= LAST_IDX;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt  <= '0;
            r_mask      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_last_id   <= w_last_id_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt  <= w_hold_nxt;
            r_mask      <= w_mask_nxt;
            r_timeout   <= w_timeout_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;

endmodule
